pc_step_conditioner: RTL and testbench

//  Front end of the PC counter: conditions board switches and a "step" push-button.

---
 rtl/pc_step_conditioner.sv | 162 ++++++++++++++++
 tb/tb_pc_step_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_step_conditioner.sv
//==============================================================================
// pc_step_conditioner : synchronises/debounces the step button and freezes the
//                       op/jump switches, emitting one step_o pulse per press.
// Rev 1.0
//==============================================================================
`default_nettype none

module pc_step_conditioner #(
    parameter int W        = 4,
    parameter int DEB_CYC  = 100000,
    parameter int HOLD_CYC = 5000000,
    parameter int REP_CYC  = 2000000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         btn_i,
    input  logic [1:0]   pcop_i,
    input  logic [W-1:0] salto_i,
    output logic         step_o,
    output logic [1:0]   pcop_o,
    output logic [W-1:0] salto_o,
    output logic         held_o
);

    localparam int c_MAX0 = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
    localparam int c_MAX1 = (c_MAX0 > REP_CYC) ? c_MAX0 : REP_CYC;
    localparam int c_CW   = (c_MAX1 > 0) ? $clog2(c_MAX1 + 1) : 1;

    localparam logic [c_CW-1:0] c_DEB_LAST  = c_CW'((DEB_CYC  > 0) ? DEB_CYC  - 1 : 0);
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    // A repeat period of 1 would give back-to-back pulses; clamp to 2.
    localparam logic [c_CW-1:0] c_REP_LAST  = c_CW'((REP_CYC  > 1) ? REP_CYC  - 1 : 1);
    localparam bit              c_REP_EN    = (HOLD_CYC > 0) && (REP_CYC > 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEB_PRESS = 3'd1,
        S_PRESSED   = 3'd2,
        S_REPEAT    = 3'd3,
        S_DEB_REL   = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_ret_rep;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] r_dcnt;
    logic            r_btn_s1, r_btn_s2;
    logic [1:0]      r_pcop_s1, r_pcop_s2;
    logic [W-1:0]    r_salto_s1, r_salto_s2;
    logic            r_step;
    logic [1:0]      r_pcop;
    logic [W-1:0]    r_salto;
    logic            r_held;

    logic [c_CW-1:0] w_cnt_inc;
    logic [c_CW-1:0] w_dcnt_inc;

    assign w_cnt_inc  = (r_cnt  == {c_CW{1'b1}}) ? r_cnt  : r_cnt  + c_CW'(1);
    assign w_dcnt_inc = (r_dcnt == {c_CW{1'b1}}) ? r_dcnt : r_dcnt + c_CW'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_ret_rep  <= 1'b0;
            r_cnt      <= '0;
            r_dcnt     <= '0;
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_pcop_s1  <= '0;
            r_pcop_s2  <= '0;
            r_salto_s1 <= '0;
            r_salto_s2 <= '0;
            r_step     <= 1'b0;
            r_pcop     <= '0;
            r_salto    <= '0;
            r_held     <= 1'b0;
        end else begin
            r_btn_s1   <= btn_i;
            r_btn_s2   <= r_btn_s1;
            r_pcop_s1  <= pcop_i;
            r_pcop_s2  <= r_pcop_s1;
            r_salto_s1 <= salto_i;
            r_salto_s2 <= r_salto_s1;
            r_step     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_btn_s2) begin
                        r_state <= S_DEB_PRESS;
                        r_dcnt  <= '0;
                    end
                end
                S_DEB_PRESS: begin
                    if (!r_btn_s2) begin
                        r_state <= S_IDLE;
                    end else if (r_dcnt == c_DEB_LAST) begin
                        r_state <= S_PRESSED;
                        r_held  <= 1'b1;
                        r_step  <= 1'b1;
                        r_pcop  <= r_pcop_s2;
                        r_salto <= r_salto_s2;
                        r_cnt   <= '0;
                    end else begin
                        r_dcnt  <= w_dcnt_inc;
                    end
                end
                S_PRESSED: begin
                    if (!r_btn_s2) begin
                        r_state   <= S_DEB_REL;
                        r_ret_rep <= 1'b0;
                        r_dcnt    <= '0;
                    end else if (c_REP_EN && (r_cnt == c_HOLD_LAST)) begin
                        r_state <= S_REPEAT;
                        r_step  <= 1'b1;
                        r_pcop  <= r_pcop_s2;
                        r_salto <= r_salto_s2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                S_REPEAT: begin
                    if (!r_btn_s2) begin
                        r_state   <= S_DEB_REL;
                        r_ret_rep <= 1'b1;
                        r_dcnt    <= '0;
                    end else if (r_cnt == c_REP_LAST) begin
                        r_step  <= 1'b1;
                        r_pcop  <= r_pcop_s2;
                        r_salto <= r_salto_s2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                S_DEB_REL: begin
                    // A glitch resumes the interrupted state; r_cnt was left frozen.
                    if (r_btn_s2) begin
                        r_state <= r_ret_rep ? S_REPEAT : S_PRESSED;
                    end else if (r_dcnt == c_DEB_LAST) begin
                        r_state <= S_IDLE;
                        r_held  <= 1'b0;
                    end else begin
                        r_dcnt  <= w_dcnt_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign step_o  = r_step;
    assign pcop_o  = r_pcop;
    assign salto_o = r_salto;
    assign held_o  = r_held;

endmodule

`default_nettype wire

// File: tb/tb_pc_step_conditioner.sv
//==============================================================================
// tb_pc_step_conditioner : directed bench for the step-button conditioner.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_pc_step_conditioner;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       btn_i;
    logic [1:0] pcop_i;
    logic [3:0] salto_i;
    logic       step_o;
    logic [1:0] pcop_o;
    logic [3:0] salto_o;
    logic       held_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0;
    int t1;

    int         q_cyc[$];
    logic [1:0] q_pcop[$];
    logic [3:0] q_salto[$];

    pc_step_conditioner #(
        .W        (4),
        .DEB_CYC  (8),
        .HOLD_CYC (40),
        .REP_CYC  (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_i),
        .pcop_i  (pcop_i),
        .salto_i (salto_i),
        .step_o  (step_o),
        .pcop_o  (pcop_o),
        .salto_o (salto_o),
        .held_o  (held_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (step_o === 1'b1) begin
            q_cyc.push_back(cyc);
            q_pcop.push_back(pcop_o);
            q_salto.push_back(salto_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic int qc(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1;
    endfunction

    function automatic int qp(input int i);
        return (i < q_pcop.size()) ? int'(q_pcop[i]) : -1;
    endfunction

    function automatic int qs(input int i);
        return (i < q_salto.size()) ? int'(q_salto[i]) : -1;
    endfunction

    task automatic clear_q();
        q_cyc.delete();
        q_pcop.delete();
        q_salto.delete();
    endtask

    initial begin
        rst_i   = 1'b0;
        btn_i   = 1'b0;
        pcop_i  = 2'd0;
        salto_i = 4'd0;
        wait_cyc(3);
        chk("rst_step",  32'(step_o),  32'd0);
        chk("rst_pcop",  32'(pcop_o),  32'd0);
        chk("rst_salto", 32'(salto_o), 32'd0);
        chk("rst_held",  32'(held_o),  32'd0);
        rst_i = 1'b1;
        wait_cyc(5);

        // Clean press: one step 11 cycles after the edge
        pcop_i  = 2'b10;
        salto_i = 4'hA;
        wait_cyc(4);
        t0 = cyc;
        btn_i = 1'b1;
        wait_cyc(20);
        chk("clean_held_on", 32'(held_o), 32'd1);
        btn_i = 1'b0;
        wait_cyc(20);
        chk("clean_held_off", 32'(held_o), 32'd0);
        chk("clean_nsteps",   32'(q_cyc.size()), 32'd1);
        chk("clean_cyc",      32'(qc(0)), 32'(t0 + 11));
        chk("clean_pcop",     32'(qp(0)), 32'd2);
        chk("clean_salto",    32'(qs(0)), 32'hA);
        clear_q();

        // Bouncing press: nothing until 8 stable cycles
        for (int i = 0; i < 10; i++) begin
            btn_i = (i % 2 == 0);
            wait_cyc(3);
        end
        chk("bounce_nosteps", 32'(q_cyc.size()), 32'd0);
        t0 = cyc;
        btn_i = 1'b1;
        wait_cyc(20);
        btn_i = 1'b0;
        wait_cyc(20);
        chk("bounce_nsteps", 32'(q_cyc.size()), 32'd1);
        chk("bounce_cyc",    32'(qc(0)), 32'(t0 + 11));
        clear_q();

        // Long hold with auto-repeat; salto changes before the first repeat
        pcop_i  = 2'd1;
        salto_i = 4'h3;
        wait_cyc(4);
        t0 = cyc;
        btn_i = 1'b1;
        wait_cyc(20);
        salto_i = 4'h7;
        wait_cyc(10);
        chk("frozen_salto", 32'(salto_o), 32'h3);
        wait_cyc(81);
        btn_i = 1'b0;
        wait_cyc(30);
        chk("rep_nsteps", 32'(q_cyc.size()), 32'd5);
        chk("rep_cyc0",   32'(qc(0)), 32'(t0 + 11));
        chk("rep_cyc1",   32'(qc(1)), 32'(t0 + 51));
        chk("rep_cyc2",   32'(qc(2)), 32'(t0 + 67));
        chk("rep_cyc3",   32'(qc(3)), 32'(t0 + 83));
        chk("rep_cyc4",   32'(qc(4)), 32'(t0 + 99));
        chk("rep_salto0", 32'(qs(0)), 32'h3);
        chk("rep_salto1", 32'(qs(1)), 32'h7);
        chk("rep_salto4", 32'(qs(4)), 32'h7);
        chk("rep_pcop1",  32'(qp(1)), 32'd1);
        clear_q();

        // Short release glitch then re-press: still a single step
        pcop_i  = 2'd3;
        salto_i = 4'h5;
        wait_cyc(4);
        t0 = cyc;
        btn_i = 1'b1;
        wait_cyc(20);
        btn_i = 1'b0;
        wait_cyc(5);
        btn_i = 1'b1;
        wait_cyc(2);
        chk("glitch_held", 32'(held_o), 32'd1);
        wait_cyc(8);
        btn_i = 1'b0;
        wait_cyc(20);
        chk("glitch_held_off", 32'(held_o), 32'd0);
        chk("glitch_nsteps",   32'(q_cyc.size()), 32'd1);
        chk("glitch_cyc",      32'(qc(0)), 32'(t0 + 11));
        clear_q();
        t0 = cyc;
        btn_i = 1'b1;
        wait_cyc(15);
        btn_i = 1'b0;
        wait_cyc(20);
        chk("repress_nsteps", 32'(q_cyc.size()), 32'd1);
        chk("repress_cyc",    32'(qc(0)), 32'(t0 + 11));
        chk("repress_salto",  32'(qs(0)), 32'h5);
        clear_q();

        // Reset while in REPEAT with the button still held
        pcop_i  = 2'd2;
        salto_i = 4'h9;
        wait_cyc(4);
        t0 = cyc;
        btn_i = 1'b1;
        wait_cyc(55);
        rst_i = 1'b0;
        #1;
        chk("mrst_step",  32'(step_o),  32'd0);
        chk("mrst_pcop",  32'(pcop_o),  32'd0);
        chk("mrst_salto", 32'(salto_o), 32'd0);
        chk("mrst_held",  32'(held_o),  32'd0);
        wait_cyc(2);
        rst_i = 1'b1;
        t1 = cyc;
        wait_cyc(15);
        btn_i = 1'b0;
        wait_cyc(20);
        chk("mrst_nsteps", 32'(q_cyc.size()), 32'd3);
        chk("mrst_cyc0",   32'(qc(0)), 32'(t0 + 11));
        chk("mrst_cyc1",   32'(qc(1)), 32'(t0 + 51));
        chk("mrst_cyc2",   32'(qc(2)), 32'(t1 + 11));
        chk("mrst_salto2", 32'(qs(2)), 32'h9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
